// File: rtl/dec16_gate_sched_pkg.sv
// Shared types and sizes for the 16-way gated-decoder scheduler.
package dec16_gate_sched_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int TEN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

endpackage

// File: rtl/dec16_gate_sched_rr16_pick.sv
// Round-robin picker: first set request at or above (ptr + 1) mod 16, wrapping.
module rr16_pick
    import dec16_gate_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    assign start = ptr + 1'b1;
    // rot[i] = req[(start + i) mod 16], so bit 0 is the highest-priority requester.
    assign rot   = N_REQ'({req, req} >> start);
    assign any   = |req;

    // NOTE: off gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign idx = start + off;

endmodule

// File: rtl/dec16_gate_sched.sv
// Round-robin scheduler driving one 4-to-16 active-low-gated decoder;
// one dead cycle separates consecutive grants so decoded enables never overlap.
module dec16_gate_sched
    import dec16_gate_sched_pkg::*;
#(
    parameter int MAXT = 15
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] a,
    output logic             gn,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             sw
);

    state_t           state;
    logic [TEN_W-1:0] ten_cnt;
    logic             rst_meta;
    logic             rst_int_n;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             tenure_done;

    // Assertion is immediate; release reaches the FSM only after two clean edges.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            rst_meta  <= 1'b0;
            rst_int_n <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_int_n <= rst_meta;
        end
    end

    rr16_pick u_pick (
        .req (req),
        .ptr (gnt_idx),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign tenure_done = (MAXT != 0) && (ten_cnt == TEN_W'(MAXT - 1));

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state   <= IDLE;
            gnt_idx <= 4'hF;
            a       <= 4'h0;
            gn      <= 1'b1;
            busy    <= 1'b0;
            sw      <= 1'b0;
            ten_cnt <= '0;
        end else begin
            sw <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pick_any) begin
                        state   <= GRANT;
                        gnt_idx <= pick_idx;
                        a       <= ~pick_idx;
                        gn      <= 1'b0;
                        busy    <= 1'b1;
                        sw      <= 1'b1;
                        ten_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        gn    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (ten_cnt != '1) ten_cnt <= ten_cnt + 1'b1;
                    // Request drop and tenure expiry collapse into one exit.
                    if (!req[gnt_idx] || tenure_done) begin
                        state <= GAP;
                        gn    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gn    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec16_gate_sched.sv
// Bench for dec16_gate_sched: four instances with different tenure limits,
// each followed by a behavioural 4-to-16 gated decoder.
module tb_dec16_gate_sched;

    localparam int N_DUT = 4;

    typedef struct {
        int          dut;
        logic [15:0] req;
        logic        exp_gn;
        logic [3:0]  exp_idx;
        logic        exp_sw;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        resetl  = 1'b1;
    logic [15:0] req_v  [N_DUT];
    logic [3:0]  a_v    [N_DUT];
    logic        gn_v   [N_DUT];
    logic [3:0]  idx_v  [N_DUT];
    logic        busy_v [N_DUT];
    logic        sw_v   [N_DUT];
    logic [15:0] z_v    [N_DUT];

    vec_t vecs  [$];
    vec_t exp_q [$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step    = 0;

    always #5 sys_clk = ~sys_clk;

    // Instance 0: MAXT=0, 1: MAXT=4, 2: MAXT=3, 3: MAXT=1.
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int MAXT_G = (g == 0) ? 0 : (g == 1) ? 4 : (g == 2) ? 3 : 1;
        dec16_gate_sched #(.MAXT(MAXT_G)) u_dut (
            .sys_clk (sys_clk),
            .resetl  (resetl),
            .req     (req_v[g]),
            .a       (a_v[g]),
            .gn      (gn_v[g]),
            .gnt_idx (idx_v[g]),
            .busy    (busy_v[g]),
            .sw      (sw_v[g])
        );
        // Decoder line n is enabled when select = ~n and the gate is low.
        assign z_v[g] = gn_v[g] ? 16'h0000 : (16'h0001 << ~a_v[g]);
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_reset(string tag);
        for (int d = 0; d < N_DUT; d++) begin
            check($sformatf("%s/dut%0d gn", tag, d),      16'(gn_v[d]),   16'h0001);
            check($sformatf("%s/dut%0d gnt_idx", tag, d), 16'(idx_v[d]),  16'h000F);
            check($sformatf("%s/dut%0d a", tag, d),       16'(a_v[d]),    16'h0000);
            check($sformatf("%s/dut%0d busy", tag, d),    16'(busy_v[d]), 16'h0000);
            check($sformatf("%s/dut%0d sw", tag, d),      16'(sw_v[d]),   16'h0000);
        end
    endtask

    task automatic check_vec(vec_t e);
        string       tag;
        logic [3:0]  exp_a;
        logic [15:0] exp_z;
        tag   = $sformatf("v%0d/dut%0d", step, e.dut);
        exp_a = ~e.exp_idx;
        exp_z = e.exp_gn ? 16'h0000 : (16'h0001 << e.exp_idx);
        check({tag, " gn"},      16'(gn_v[e.dut]),   16'(e.exp_gn));
        check({tag, " gnt_idx"}, 16'(idx_v[e.dut]),  16'(e.exp_idx));
        check({tag, " a"},       16'(a_v[e.dut]),    16'(exp_a));
        check({tag, " busy"},    16'(busy_v[e.dut]), 16'(!e.exp_gn));
        check({tag, " sw"},      16'(sw_v[e.dut]),   16'(e.exp_sw));
        check({tag, " z"},       z_v[e.dut],         exp_z);
        step++;
    endtask

    function automatic void add(int d, logic [15:0] r, logic g, logic [3:0] i, logic s);
        vecs.push_back('{dut: d, req: r, exp_gn: g, exp_idx: i, exp_sw: s});
    endfunction

    // Each vector drives its request at the falling edge and is checked just after the next rising edge.
    task automatic run_vecs();
        vec_t v;
        vec_t e;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            @(negedge sys_clk);
            req_v[v.dut] = v.req;
            exp_q.push_back(v);
            @(posedge sys_clk);
            #1;
            e = exp_q.pop_front();
            check_vec(e);
        end
    endtask

    initial begin
        for (int d = 0; d < N_DUT; d++) req_v[d] = 16'h0000;

        // Power-on reset, with req[0] already waiting on instance 0.
        #2 resetl = 1'b0;
        req_v[0] = 16'h0001;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset("por");
        @(posedge sys_clk);
        #2 resetl = 1'b1;

        // Instance 0 (unlimited tenure): no grant before the third edge after release.
        add(0, 16'h0001, 1'b1, 4'hF, 1'b0);
        add(0, 16'h0001, 1'b1, 4'hF, 1'b0);
        add(0, 16'h0001, 1'b0, 4'h0, 1'b1);
        for (int k = 0; k < 20; k++) add(0, 16'h0001, 1'b0, 4'h0, 1'b0);
        add(0, 16'h0000, 1'b1, 4'h0, 1'b0);
        add(0, 16'h0000, 1'b1, 4'h0, 1'b0);
        // From IDLE: grant one edge after the request appears.
        add(0, 16'h0001, 1'b0, 4'h0, 1'b1);
        add(0, 16'h0001, 1'b0, 4'h0, 1'b0);
        add(0, 16'h0000, 1'b1, 4'h0, 1'b0);
        add(0, 16'h0000, 1'b1, 4'h0, 1'b0);
        // req[4] drops in its second grant cycle, then req[8] after one gap.
        add(0, 16'h0110, 1'b0, 4'h4, 1'b1);
        add(0, 16'h0110, 1'b0, 4'h4, 1'b0);
        add(0, 16'h0100, 1'b1, 4'h4, 1'b0);
        add(0, 16'h0100, 1'b0, 4'h8, 1'b1);
        add(0, 16'h0100, 1'b0, 4'h8, 1'b0);
        // Wrap-around: from 15 with 0 and 14 pending, 0 wins.
        add(0, 16'h8000, 1'b1, 4'h8, 1'b0);
        add(0, 16'h8000, 1'b0, 4'hF, 1'b1);
        add(0, 16'hC001, 1'b0, 4'hF, 1'b0);
        add(0, 16'h4001, 1'b1, 4'hF, 1'b0);
        add(0, 16'h4001, 1'b0, 4'h0, 1'b1);
        add(0, 16'h4001, 1'b0, 4'h0, 1'b0);
        // Move instance 0 onto requester 9 and leave it granted.
        add(0, 16'h0200, 1'b1, 4'h0, 1'b0);
        add(0, 16'h0200, 0, 4'h9, 1'b1);
        add(0, 16'h0200, 1'b0, 4'h9, 1'b0);

        // Instance 1 (MAXT=4): 0 and 15 alternate, 4 on / 1 off.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++)
                add(1, 16'h8001, 1'b0, (r % 2 == 0) ? 4'h0 : 4'hF, k == 0);
            add(1, 16'h8001, 1'b1, (r % 2 == 0) ? 4'h0 : 4'hF, 1'b0);
        end
        add(1, 16'h0000, 1'b1, 4'hF, 1'b0);

        // Instance 2 (MAXT=3): lone requester 5, 3 on / 1 off.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) add(2, 16'h0020, 1'b0, 4'h5, k == 0);
            add(2, 16'h0020, 1'b1, 4'h5, 1'b0);
        end
        add(2, 16'h0000, 1'b1, 4'h5, 1'b0);

        // Instance 3 (MAXT=1): 1-cycle grants; drop coinciding with expiry gives one gap.
        add(3, 16'h0041, 1'b0, 4'h0, 1'b1);
        add(3, 16'h0041, 1'b1, 4'h0, 1'b0);
        add(3, 16'h0041, 1'b0, 4'h6, 1'b1);
        add(3, 16'h0041, 1'b1, 4'h6, 1'b0);
        add(3, 16'h0041, 1'b0, 4'h0, 1'b1);
        add(3, 16'h0040, 1'b1, 4'h0, 1'b0);
        add(3, 16'h0040, 1'b0, 4'h6, 1'b1);
        add(3, 16'h0040, 1'b1, 4'h6, 1'b0);
        add(3, 16'h0040, 1'b0, 4'h6, 1'b1);
        add(3, 16'h0000, 1'b1, 4'h6, 1'b0);
        add(3, 16'h0000, 1'b1, 4'h6, 1'b0);
        run_vecs();

        // Reset in the middle of instance 0's grant to requester 9.
        @(negedge sys_clk);
        check("pre-reset gn", 16'(gn_v[0]), 16'h0000);
        check("pre-reset gnt_idx", 16'(idx_v[0]), 16'h0009);
        resetl = 1'b0;
        #1;
        check_reset("midgrant");
        repeat (2) @(posedge sys_clk);
        #2 resetl = 1'b1;
        add(0, 16'h0200, 1'b1, 4'hF, 1'b0);
        add(0, 16'h0200, 1'b1, 4'hF, 1'b0);
        add(0, 16'h0200, 1'b0, 4'h9, 1'b1);

        // Instance 3 with every line requesting: each index gets one grant, one z line each.
        for (int i = 0; i < 16; i++) begin
            add(3, 16'hFFFF, 1'b0, 4'(i), 1'b1);
            add(3, 16'hFFFF, 1'b1, 4'(i), 1'b0);
        end
        add(3, 16'h0000, 1'b1, 4'hF, 1'b0);
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
